// File: rtl/aclock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aclock_pkg
// Description : Shared types and constants for the aclock front-panel
//               set-controller: edit state encoding, BCD limits and
//               edit_field codes.
// Revision    : 1.0 - initial release
// ============================================================================
package aclock_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_T_HOUR = 3'd1,
    S_T_MIN  = 3'd2,
    S_A_HOUR = 3'd3,
    S_A_MIN  = 3'd4,
    S_LOAD   = 3'd5
  } state_e;

  // BCD limits for 24-hour clock digits
  localparam logic [1:0] HOUR_MAX_H1 = 2'd2;
  localparam logic [3:0] HOUR_MAX_H0 = 4'd3;
  localparam logic [3:0] MIN_MAX_M1  = 4'd5;
  localparam logic [3:0] DIGIT_MAX   = 4'd9;

  // edit_field codes
  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/aclock_bcd_inc.sv
`default_nettype none
// ============================================================================
// Module      : aclock_bcd_inc
// Description : Combinational BCD incrementer for a two-digit hour (00-23)
//               or minute (00-59) field. Out-of-range values wrap to 00.
// Revision    : 1.0 - initial release
// ============================================================================
module aclock_bcd_inc
  import aclock_pkg::*;
(
  input  logic       hour_mode_i,
  input  logic [3:0] d1_i,
  input  logic [3:0] d0_i,
  output logic [3:0] d1_o,
  output logic [3:0] d0_o
);

  // Hour tens digit only ever holds 0..3, so only its low two bits matter
  logic [1:0] h1;
  assign h1 = d1_i[1:0];

  // Next-value selection for hour or minute field
  always_comb begin
    d1_o = d1_i;
    d0_o = d0_i;
    if (hour_mode_i) begin
      if ((h1 == 2'd3) || ((h1 >= HOUR_MAX_H1) && (d0_i >= HOUR_MAX_H0))) begin
        d1_o = 4'd0;
        d0_o = 4'd0;
      end else if (d0_i == DIGIT_MAX) begin
        d1_o = {2'b00, h1 + 2'd1};
        d0_o = 4'd0;
      end else begin
        d1_o = {2'b00, h1};
        d0_o = d0_i + 4'd1;
      end
    end else begin
      if ((d1_i > MIN_MAX_M1) || ((d1_i >= MIN_MAX_M1) && (d0_i >= DIGIT_MAX))) begin
        d1_o = 4'd0;
        d0_o = 4'd0;
      end else if (d0_i >= DIGIT_MAX) begin
        d1_o = d1_i + 4'd1;
        d0_o = 4'd0;
      end else begin
        d0_o = d0_i + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/aclock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aclock_set_ctrl
// Description : Front-panel sequencer for the aclock core. Turns button
//               pulses into BCD hour/minute edits, issues LD_time/LD_alarm
//               load strobes and holds the AL_ON alarm enable.
// Revision    : 1.0 - initial release
// ============================================================================
module aclock_set_ctrl
  import aclock_pkg::*;
#(
  parameter int LD_HOLD        = 2,
  parameter int TIMEOUT_CYCLES = 600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_set,
  input  logic       btn_alarm,
  input  logic [1:0] cur_h1,
  input  logic [3:0] cur_h0,
  input  logic [3:0] cur_m1,
  input  logic [3:0] cur_m0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       AL_ON,
  output logic       edit_active,
  output logic [1:0] edit_field
);

  // Counter widths sized to hold the last count value
  localparam int TO_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int HOLD_W = (LD_HOLD > 2) ? $clog2(LD_HOLD) : 1;
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LD_HOLD - 1);

  state_e            state_q;
  logic              target_alarm_q;
  logic [1:0]        h1_q;
  logic [3:0]        h0_q, m1_q, m0_q;
  logic [1:0]        sh_h1_q;
  logic [3:0]        sh_h0_q, sh_m1_q, sh_m0_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [HOLD_W-1:0] hold_q;
  logic              ld_time_q, ld_alarm_q, al_on_q;
  logic [1:0]        field_q;

  logic              is_hour;
  logic [3:0]        sel_d1, sel_d0, inc_d1, inc_d0;

  // Route the field under edit through the shared incrementer
  assign is_hour = (state_q == S_T_HOUR) || (state_q == S_A_HOUR);
  assign sel_d1  = is_hour ? {2'b00, h1_q} : m1_q;
  assign sel_d0  = is_hour ? h0_q : m0_q;

  aclock_bcd_inc u_bcd_inc (
    .hour_mode_i (is_hour),
    .d1_i        (sel_d1),
    .d0_i        (sel_d0),
    .d1_o        (inc_d1),
    .d0_o        (inc_d0)
  );

  // Sequencer: edit state, digit registers, alarm shadow, timers and strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      target_alarm_q <= 1'b0;
      h1_q           <= '0;
      h0_q           <= '0;
      m1_q           <= '0;
      m0_q           <= '0;
      sh_h1_q        <= '0;
      sh_h0_q        <= '0;
      sh_m1_q        <= '0;
      sh_m0_q        <= '0;
      to_cnt_q       <= '0;
      hold_q         <= '0;
      ld_time_q      <= 1'b0;
      ld_alarm_q     <= 1'b0;
      al_on_q        <= 1'b0;
      field_q        <= FIELD_NONE;
    end else begin
      if (btn_alarm) al_on_q <= ~al_on_q;
      case (state_q)
        S_IDLE: begin
          to_cnt_q <= '0;
          if (btn_mode) begin
            state_q        <= S_T_HOUR;
            target_alarm_q <= 1'b0;
            field_q        <= FIELD_HOUR;
            h1_q           <= cur_h1;
            h0_q           <= cur_h0;
            m1_q           <= cur_m1;
            m0_q           <= cur_m0;
          end
        end
        S_T_HOUR, S_T_MIN, S_A_HOUR, S_A_MIN: begin
          if (btn_mode) begin
            to_cnt_q <= '0;
            if (target_alarm_q) begin
              // Cancel alarm edit without loading
              state_q <= S_IDLE;
              field_q <= FIELD_NONE;
            end else begin
              // Abandon time edit, switch to alarm edit from the shadow
              state_q        <= S_A_HOUR;
              target_alarm_q <= 1'b1;
              field_q        <= FIELD_HOUR;
              h1_q           <= sh_h1_q;
              h0_q           <= sh_h0_q;
              m1_q           <= sh_m1_q;
              m0_q           <= sh_m0_q;
            end
          end else if (btn_set) begin
            to_cnt_q <= '0;
            if (is_hour) begin
              state_q <= target_alarm_q ? S_A_MIN : S_T_MIN;
              field_q <= FIELD_MIN;
            end else begin
              state_q    <= S_LOAD;
              field_q    <= FIELD_NONE;
              hold_q     <= '0;
              ld_time_q  <= ~target_alarm_q;
              ld_alarm_q <= target_alarm_q;
              if (target_alarm_q) begin
                sh_h1_q <= h1_q;
                sh_h0_q <= h0_q;
                sh_m1_q <= m1_q;
                sh_m0_q <= m0_q;
              end
            end
          end else if (btn_inc) begin
            to_cnt_q <= '0;
            if (is_hour) begin
              h1_q <= inc_d1[1:0];
              h0_q <= inc_d0;
            end else begin
              m1_q <= inc_d1;
              m0_q <= inc_d0;
            end
          end else if (to_cnt_q == TO_LAST) begin
            // Idle too long: drop the edit, nothing is loaded
            state_q  <= S_IDLE;
            field_q  <= FIELD_NONE;
            to_cnt_q <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        S_LOAD: begin
          if (hold_q == HOLD_LAST) begin
            state_q    <= S_IDLE;
            ld_time_q  <= 1'b0;
            ld_alarm_q <= 1'b0;
            hold_q     <= '0;
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        default: begin
          state_q    <= S_IDLE;
          field_q    <= FIELD_NONE;
          ld_time_q  <= 1'b0;
          ld_alarm_q <= 1'b0;
        end
      endcase
    end
  end

  assign H_in1       = h1_q;
  assign H_in0       = h0_q;
  assign M_in1       = m1_q;
  assign M_in0       = m0_q;
  assign LD_time     = ld_time_q;
  assign LD_alarm    = ld_alarm_q;
  assign AL_ON       = al_on_q;
  assign edit_field  = field_q;
  assign edit_active = (field_q != FIELD_NONE);

endmodule
`default_nettype wire

// File: tb/tb_aclock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aclock_set_ctrl
// Description : Self-checking bench for aclock_set_ctrl: directed vector
//               table, timeout sequences and randomized traffic against an
//               integer-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aclock_set_ctrl;

  localparam int LD_HOLD        = 2;
  localparam int TIMEOUT_CYCLES = 600;

  logic       clk = 1'b0;
  logic       reset, btn_mode, btn_inc, btn_set, btn_alarm;
  logic [1:0] cur_h1;
  logic [3:0] cur_h0, cur_m1, cur_m0;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm, AL_ON, edit_active;
  logic [1:0] edit_field;

  int n_cmp  = 0;
  int n_fail = 0;

  aclock_set_ctrl #(.LD_HOLD(LD_HOLD), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_set(btn_set), .btn_alarm(btn_alarm),
    .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .AL_ON(AL_ON),
    .edit_active(edit_active), .edit_field(edit_field)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1);
  end

  // ---------------------------------------------------------------- helpers
  typedef struct {
    logic        r, m, i, s, a;
    logic [15:0] cur;
    logic [15:0] dig;
    logic        lt, la, al;
    logic [1:0]  fld;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function void add_vec(input logic r, m, i, s, a, input logic [15:0] cur,
                        input logic [15:0] dig, input logic lt, la, al, input logic [1:0] fld);
    vec_t v;
    v.r = r; v.m = m; v.i = i; v.s = s; v.a = a; v.cur = cur;
    v.dig = dig; v.lt = lt; v.la = la; v.al = al; v.fld = fld;
    tbl.push_back(v);
  endfunction

  // Drive one cycle of inputs at the falling edge, sample after the rising edge
  task automatic tick(input logic r, m, i, s, a, input logic [15:0] cur);
    @(negedge clk);
    reset = r; btn_mode = m; btn_inc = i; btn_set = s; btn_alarm = a;
    cur_h1 = cur[13:12]; cur_h0 = cur[11:8]; cur_m1 = cur[7:4]; cur_m0 = cur[3:0];
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [15:0] edig,
                           input logic elt, ela, eal, input logic [1:0] efld);
    logic [15:0] adig;
    adig = {2'b00, H_in1, H_in0, M_in1, M_in0};
    n_cmp++;
    if (adig !== edig || LD_time !== elt || LD_alarm !== ela || AL_ON !== eal ||
        edit_field !== efld || edit_active !== (efld != 2'd0)) begin
      n_fail++;
      $display("FAIL %s: got dig=%h lt=%b la=%b al=%b act=%b fld=%0d, want dig=%h lt=%b la=%b al=%b act=%b fld=%0d",
               tag, adig, LD_time, LD_alarm, AL_ON, edit_active, edit_field,
               edig, elt, ela, eal, (efld != 2'd0), efld);
    end
  endtask

  // ------------------------------------------------------- reference model
  bit m_edit, m_alarm_tgt, m_al, m_lt, m_la;
  int m_field, m_hr, m_mn, m_sh_hr, m_sh_mn, m_idle, m_left;

  function void model_step(input bit r, bm, bi, bs, ba, input int ch, cm);
    if (r) begin
      m_edit = 0; m_alarm_tgt = 0; m_al = 0; m_lt = 0; m_la = 0; m_field = 0;
      m_hr = 0; m_mn = 0; m_sh_hr = 0; m_sh_mn = 0; m_idle = 0; m_left = 0;
      return;
    end
    if (ba) m_al = !m_al;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_lt = 0; m_la = 0; end
    end else if (!m_edit) begin
      if (bm) begin
        m_edit = 1; m_field = 1; m_alarm_tgt = 0; m_hr = ch; m_mn = cm; m_idle = 0;
      end
    end else if (bm) begin
      m_idle = 0;
      if (m_alarm_tgt) begin m_edit = 0; m_field = 0; end
      else begin m_alarm_tgt = 1; m_field = 1; m_hr = m_sh_hr; m_mn = m_sh_mn; end
    end else if (bs) begin
      m_idle = 0;
      if (m_field == 1) m_field = 2;
      else begin
        m_edit = 0; m_field = 0; m_left = LD_HOLD;
        if (m_alarm_tgt) begin m_la = 1; m_sh_hr = m_hr; m_sh_mn = m_mn; end
        else m_lt = 1;
      end
    end else if (bi) begin
      m_idle = 0;
      if (m_field == 1) m_hr = (m_hr + 1) % 24;
      else m_mn = (m_mn + 1) % 60;
    end else begin
      m_idle++;
      if (m_idle == TIMEOUT_CYCLES) begin m_edit = 0; m_field = 0; m_idle = 0; end
    end
  endfunction

  // ------------------------------------------------------------- stimulus
  initial begin
    logic [15:0] C1, C2, C3, C4, C5;
    bit saw_strobe;
    C1 = 16'h1014; C2 = 16'h2359; C3 = 16'h0909; C4 = 16'h3700; C5 = 16'h2500;
    reset = 1'b1; btn_mode = 0; btn_inc = 0; btn_set = 0; btn_alarm = 0;
    cur_h1 = 0; cur_h0 = 0; cur_m1 = 0; cur_m0 = 0;

    // Directed vector table: r m i s a cur dig lt la al fld
    add_vec(1,0,0,0,0, C1, 16'h0000, 0,0,0, 0);
    add_vec(0,1,0,0,0, C1, 16'h1014, 0,0,0, 1);
    for (int k = 1; k <= 4; k++) add_vec(0,0,1,0,0, C1, 16'h1014 + 16'(k << 8), 0,0,0, 1);
    add_vec(0,0,0,1,0, C1, 16'h1414, 0,0,0, 2);
    add_vec(0,0,1,0,0, C1, 16'h1415, 0,0,0, 2);
    add_vec(0,0,0,1,0, C1, 16'h1415, 1,0,0, 0);
    add_vec(0,0,0,0,0, C1, 16'h1415, 1,0,0, 0);
    add_vec(0,0,0,0,0, C1, 16'h1415, 0,0,0, 0);
    add_vec(0,1,0,0,0, C1, 16'h1014, 0,0,0, 1);
    add_vec(0,1,0,0,0, C1, 16'h0000, 0,0,0, 1);
    for (int k = 1; k <= 11; k++) add_vec(0,0,1,0,0, C1, {bcd(k), 8'h00}, 0,0,0, 1);
    add_vec(0,0,0,1,0, C1, 16'h1100, 0,0,0, 2);
    for (int k = 1; k <= 30; k++) add_vec(0,0,1,0,0, C1, {8'h11, bcd(k)}, 0,0,0, 2);
    add_vec(0,0,0,1,0, C1, 16'h1130, 0,1,0, 0);
    add_vec(0,0,0,0,0, C1, 16'h1130, 0,1,0, 0);
    add_vec(0,0,0,0,0, C1, 16'h1130, 0,0,0, 0);
    add_vec(0,1,0,0,0, C1, 16'h1014, 0,0,0, 1);
    add_vec(0,1,0,0,0, C1, 16'h1130, 0,0,0, 1);
    add_vec(0,1,0,0,0, C1, 16'h1130, 0,0,0, 0);
    // hour 23 wrap, minute 59 wrap
    add_vec(0,1,0,0,0, C2, 16'h2359, 0,0,0, 1);
    add_vec(0,0,1,0,0, C2, 16'h0059, 0,0,0, 1);
    add_vec(0,0,0,1,0, C2, 16'h0059, 0,0,0, 2);
    add_vec(0,0,1,0,0, C2, 16'h0000, 0,0,0, 2);
    add_vec(0,1,0,0,0, C2, 16'h1130, 0,0,0, 1);
    add_vec(0,1,0,0,0, C2, 16'h1130, 0,0,0, 0);
    // hour 09 and minute 09 carries, then mode+set in T_MIN
    add_vec(0,1,0,0,0, C3, 16'h0909, 0,0,0, 1);
    add_vec(0,0,1,0,0, C3, 16'h1009, 0,0,0, 1);
    add_vec(0,0,0,1,0, C3, 16'h1009, 0,0,0, 2);
    add_vec(0,0,1,0,0, C3, 16'h1010, 0,0,0, 2);
    add_vec(0,1,0,1,0, C3, 16'h1130, 0,0,0, 1);
    add_vec(0,1,0,0,0, C3, 16'h1130, 0,0,0, 0);
    // out-of-range hour 3:7 wraps, then inc+set in T_HOUR
    add_vec(0,1,0,0,0, C4, 16'h3700, 0,0,0, 1);
    add_vec(0,0,1,0,0, C4, 16'h0000, 0,0,0, 1);
    add_vec(0,0,1,1,0, C4, 16'h0000, 0,0,0, 2);
    add_vec(0,1,0,0,0, C4, 16'h1130, 0,0,0, 1);
    add_vec(0,1,0,0,0, C4, 16'h1130, 0,0,0, 0);
    add_vec(0,1,0,0,0, C5, 16'h2500, 0,0,0, 1);
    add_vec(0,0,1,0,0, C5, 16'h0000, 0,0,0, 1);
    add_vec(0,1,0,0,0, C5, 16'h1130, 0,0,0, 1);
    add_vec(0,1,0,0,0, C5, 16'h1130, 0,0,0, 0);
    // set/inc ignored in IDLE; AL_ON toggles in IDLE and in LOAD
    add_vec(0,0,0,1,0, C1, 16'h1130, 0,0,0, 0);
    add_vec(0,0,1,0,0, C1, 16'h1130, 0,0,0, 0);
    add_vec(0,0,0,0,1, C1, 16'h1130, 0,0,1, 0);
    add_vec(0,1,0,0,0, C1, 16'h1014, 0,0,1, 1);
    add_vec(0,0,0,1,0, C1, 16'h1014, 0,0,1, 2);
    add_vec(0,0,0,1,0, C1, 16'h1014, 1,0,1, 0);
    add_vec(0,0,0,0,1, C1, 16'h1014, 1,0,0, 0);
    add_vec(0,0,0,0,0, C1, 16'h1014, 0,0,0, 0);
    // reset in the first LOAD cycle
    add_vec(0,1,0,0,0, C1, 16'h1014, 0,0,0, 1);
    add_vec(0,0,0,1,0, C1, 16'h1014, 0,0,0, 2);
    add_vec(0,0,0,1,0, C1, 16'h1014, 1,0,0, 0);
    add_vec(1,0,0,0,0, C1, 16'h0000, 0,0,0, 0);
    add_vec(0,0,0,0,0, C1, 16'h0000, 0,0,0, 0);

    foreach (tbl[n]) begin
      tick(tbl[n].r, tbl[n].m, tbl[n].i, tbl[n].s, tbl[n].a, tbl[n].cur);
      check_out($sformatf("vec%0d", n), tbl[n].dig, tbl[n].lt, tbl[n].la, tbl[n].al, tbl[n].fld);
    end

    // Timeout: 600 silent cycles in T_MIN return to IDLE with no strobe
    saw_strobe = 0;
    tick(1,0,0,0,0, 16'h1234);
    tick(0,1,0,0,0, 16'h1234);
    tick(0,0,0,1,0, 16'h1234);
    for (int k = 0; k < TIMEOUT_CYCLES - 1; k++) begin
      tick(0,0,0,0,0, 16'h1234);
      saw_strobe |= (LD_time | LD_alarm);
    end
    check_out("timeout_599", 16'h1234, 0,0,0, 2);
    tick(0,0,0,0,0, 16'h1234);
    check_out("timeout_600", 16'h1234, 0,0,0, 0);
    // An inc on the last idle cycle restarts the count
    tick(0,1,0,0,0, 16'h1234);
    tick(0,0,0,1,0, 16'h1234);
    for (int k = 0; k < TIMEOUT_CYCLES - 1; k++) begin
      tick(0,0,0,0,0, 16'h1234);
      saw_strobe |= (LD_time | LD_alarm);
    end
    tick(0,0,1,0,0, 16'h1234);
    check_out("timeout_inc_restart", 16'h1235, 0,0,0, 2);
    for (int k = 0; k < TIMEOUT_CYCLES - 1; k++) begin
      tick(0,0,0,0,0, 16'h1234);
      saw_strobe |= (LD_time | LD_alarm);
    end
    check_out("timeout_restart_599", 16'h1235, 0,0,0, 2);
    tick(0,0,0,0,0, 16'h1234);
    check_out("timeout_restart_600", 16'h1235, 0,0,0, 0);
    n_cmp++;
    if (saw_strobe) begin
      n_fail++;
      $display("FAIL timeout_no_strobe: got strobe=1, want strobe=0");
    end

    // Randomized traffic against the reference model
    tick(1,0,0,0,0, 16'h0000);
    model_step(1,0,0,0,0, 0, 0);
    check_out("rand_reset", 16'h0000, 0,0,0, 0);
    for (int n = 0; n < 3000; n++) begin
      logic r, bm, bi, bs, ba;
      int ch, cm;
      r  = ($urandom_range(0, 499) == 0);
      bm = ($urandom_range(0, 11) == 0);
      bs = ($urandom_range(0, 7) == 0);
      bi = ($urandom_range(0, 3) == 0);
      ba = ($urandom_range(0, 15) == 0);
      ch = $urandom_range(0, 23);
      cm = $urandom_range(0, 59);
      tick(r, bm, bi, bs, ba, {bcd(ch), bcd(cm)});
      model_step(r, bm, bi, bs, ba, ch, cm);
      check_out($sformatf("rand%0d", n), {bcd(m_hr), bcd(m_mn)}, m_lt, m_la, m_al, 2'(m_field));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
